div_unit_iter: RTL and testbench
================================

Name: div_unit_iter

Overview:
- Multi-cycle iterative integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside alu_new in the execute stage and accepts the same operand pair (alu_operand_1_i / alu_operand_2_i sourcing).
- Returns the result to the writeback mux through a start/ready/valid handshake.
- The pipeline stalls while busy; the stage can abort an operation with a flush.

Parameters:
- DW, 32, operand/result width in bits; must be at least 4 and even.
- CW, $clog2(DW)+1, iteration counter width (derived; not overridden).

Ports:
- clk_i  input  1  clock, rising-edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  request; accepted only when ready_o=1.
- op_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled at accept.
- dividend_i  input  DW  rs1 value; sampled at accept.
- divisor_i  input  DW  rs2 value; sampled at accept.
- flush_i  input  1  abort any in-flight operation.
- ready_o  output  1  high in IDLE and DONE (able to accept).
- busy_o  output  1  high in CALC.
- valid_o  output  1  one-cycle pulse, result_o valid.
- result_o  output  DW  quotient or remainder; held until next accept.

Behaviour:
- Clock and reset: one clock (clk_i); reset is asynchronous and active-low (rst_ni).
- Reset values: state=IDLE, ready_o=1, busy_o=0, valid_o=0, result_o=0, counter=0, internal registers=0.
- States:
  - IDLE: on start_i, latch operands and op, then branch. Divisor==0 or signed overflow goes to DONE. Otherwise compute magnitudes and go to CALC with counter=DW.
  - CALC: one restoring step per cycle. Shift {rem,quot} left by 1, trial-subtract |divisor|. If non-negative, keep the difference and set quot LSB=1. Decrement the counter; at counter==1 the step completes and the next state is DONE.
  - DONE: valid_o=1 for exactly this cycle; result_o registered. Return to IDLE, or accept a new start_i in the same cycle (back-to-back allowed, ready_o=1 in DONE).
- Latency from the accept edge:
  - Normal: valid_o asserts DW+1 cycles after accept (33 for DW=32).
  - Special case: valid_o asserts 1 cycle after accept.
- Signed ops (DIV/REM):
  - Operate on magnitudes.
  - Quotient negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Negation is two's complement, modulo 2^DW.
- Divide by zero (divisor==0): quotient = all ones (-1 / 2^DW-1); remainder = dividend. Applies to signed and unsigned.
- Signed overflow (DIV/REM, dividend = -2^(DW-1), divisor = -1): quotient = dividend; remainder = 0.
- Unsigned ops: no sign handling; full DW-bit magnitude.
- flush_i:
  - In any state, next state is IDLE and valid_o is suppressed that cycle.
  - result_o keeps its previous value.
  - flush_i has priority over start_i in the same cycle (request not accepted).
- Ignored inputs: start_i while busy_o=1 is ignored (ready_o=0). Operand inputs may change after accept without effect.
- Asynchronous reset mid-CALC: immediate return to reset values; no valid_o.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Enabled:
  - In IDLE, if |dividend| < |divisor| (unsigned compare of magnitudes, divisor nonzero), skip CALC and go straight to DONE.
  - Result is quotient=0, remainder=dividend (original signed value).
  - valid_o asserts 1 cycle after accept.
- Disabled: such cases take the full DW+1 latency with identical results.
- Results are bit-identical either way; only latency differs.

Test Plan:
- DIVU 100/5 -> valid_o exactly 33 cycles after accept, result_o=20; REMU 101010/3 -> result_o=0; REMU 1111/2 -> 1.
- DIV -23/4 -> result_o=-5 (0xFFFFFFFB); REM -23/4 -> -3 (0xFFFFFFFD); DIV 23/-4 -> -5; REM 23/-4 -> 3.
- Divisor 0: DIVU 9999/0 -> 0xFFFFFFFF after 1 cycle; REM 9999/0 -> 9999. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- Flush: start DIVU 34/3, assert flush_i at cycle 10 -> no valid_o, ready_o=1 next cycle, result_o unchanged. Then DIVU 34/3 -> 11.
- Back-to-back: new start_i in the DONE cycle with DIVU 9999/1 -> accepted; valid_o pulses for both; second result 9999. start_i held during CALC -> ignored.
- Reset: drop rst_ni mid-CALC -> outputs at reset values asynchronously, before the next clock edge. With DIV_EARLY_OUT_EN, DIVU 3/34 -> result 0 after 1 cycle; REMU 3/34 -> 3.

Source files
------------

// File: rtl/div_unit_iter.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU with start/ready/valid handshake.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration loop when |dividend| < |divisor|.
module div_unit_iter #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [1:0]    op_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  input  logic          flush_i,
  output logic          ready_o,
  output logic          busy_o,
  output logic          valid_o,
  output logic [DW-1:0] result_o
);

  localparam int CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [DW-1:0] rem;
  logic [DW-1:0] quot;
  logic [DW-1:0] div_mag;
  logic          is_rem;
  logic          neg_quot;
  logic          neg_rem;
  logic          valid_q;

  logic          is_signed;
  logic          a_neg;
  logic          b_neg;
  logic [DW-1:0] a_mag;
  logic [DW-1:0] b_mag;
  logic          div_zero;
  logic          overflow;
  logic          early;
  logic [DW-1:0] special_q;
  logic [DW-1:0] special_r;

  // Operand decode at accept time: magnitudes, sign bookkeeping and the one-cycle special cases.
  always_comb begin
    is_signed = ~op_i[0];
    a_neg     = is_signed & dividend_i[DW-1];
    b_neg     = is_signed & divisor_i[DW-1];
    a_mag     = a_neg ? (~dividend_i + 1'b1) : dividend_i;
    b_mag     = b_neg ? (~divisor_i + 1'b1) : divisor_i;
    div_zero  = (divisor_i == '0);
    overflow  = is_signed && (dividend_i == {1'b1, {(DW-1){1'b0}}}) && (divisor_i == '1);
`ifdef DIV_EARLY_OUT_EN
    early     = ~div_zero & (a_mag < b_mag);
`else
    early     = 1'b0;
`endif
    special_q = div_zero ? '1 : (overflow ? dividend_i : '0);
    special_r = (div_zero | early) ? dividend_i : '0;
  end

  logic [DW:0]   trial;
  logic [DW-1:0] rem_step;
  logic [DW-1:0] quot_step;
  logic [DW-1:0] final_val;

  // One restoring step; the partial remainder always stays below div_mag, so DW bits hold it.
  always_comb begin
    trial     = {rem, quot[DW-1]} - {1'b0, div_mag};
    rem_step  = trial[DW] ? {rem[DW-2:0], quot[DW-1]} : trial[DW-1:0];
    quot_step = {quot[DW-2:0], ~trial[DW]};
    if (is_rem) begin
      final_val = neg_rem ? (~rem_step + 1'b1) : rem_step;
    end else begin
      final_val = neg_quot ? (~quot_step + 1'b1) : quot_step;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      count    <= '0;
      rem      <= '0;
      quot     <= '0;
      div_mag  <= '0;
      is_rem   <= 1'b0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      valid_q  <= 1'b0;
      ready_o  <= 1'b1;
      busy_o   <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      state   <= IDLE;
      count   <= '0;
      valid_q <= 1'b0;
      ready_o <= 1'b1;
      busy_o  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          valid_q <= 1'b0;
          if (start_i) begin
            is_rem   <= op_i[1];
            neg_quot <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            if (div_zero || overflow || early) begin
              state    <= DONE;
              valid_q  <= 1'b1;
              result_o <= op_i[1] ? special_r : special_q;
              ready_o  <= 1'b1;
              busy_o   <= 1'b0;
            end else begin
              state   <= CALC;
              count   <= CW'(DW);
              rem     <= '0;
              quot    <= a_mag;
              div_mag <= b_mag;
              ready_o <= 1'b0;
              busy_o  <= 1'b1;
            end
          end else begin
            state   <= IDLE;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
          end
        end
        CALC: begin
          rem   <= rem_step;
          quot  <= quot_step;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state    <= DONE;
            valid_q  <= 1'b1;
            result_o <= final_val;
            ready_o  <= 1'b1;
            busy_o   <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving in the DONE cycle still hides the pulse.
  assign valid_o = valid_q & ~flush_i;

endmodule

// File: tb/tb_div_unit_iter.sv
// Scoreboard bench for div_unit_iter: directed RV32M cases plus randomized ops against an arithmetic model.
// Honours DIV_EARLY_OUT_EN for the expected latency.
module tb_div_unit_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic        ready;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    logic [31:0] res;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  div_unit_iter #(.DW(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .op_i       (op),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .flush_i    (flush),
    .ready_o    (ready),
    .busy_o     (busy),
    .valid_o    (valid),
    .result_o   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: RV32M semantics from plain integer arithmetic.
  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb_v;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : a;
      sa   = a;
      sb_v = b;
      return o[1] ? 32'(sa % sb_v) : 32'(sa / sb_v);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint ma;
    longint mb;
    if (b == 32'd0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    if (!o[0]) begin
      ma = longint'($signed(a));
      mb = longint'($signed(b));
      if (ma < 0) ma = -ma;
      if (mb < 0) mb = -mb;
    end else begin
      ma = longint'(a);
      mb = longint'(b);
    end
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`else
    if (ma < mb) return 33;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 50));
      4:       return 32'd0 - 32'($urandom_range(1, 50));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called at a negedge: waits for ready, presents one request for a single cycle.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_out);
    exp_t e;
    int w = 0;
    while (!ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("[TB] FAIL ready_wait: ready stayed 0, expected 1 within 200 cycles");
    end
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    if (expect_out) begin
      e.res = model_res(o, a, b);
      e.acc = cyc + 1;
      e.lat = model_lat(o, a, b);
      sb.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    op       = 2'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic drain();
    int w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding request, result and latency.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_valid: result 0x%08h with nothing outstanding", result);
      end else begin
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        last_res = e.res;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    dividend = '0;
    divisor  = '0;
    flush    = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(2'b01, 32'd100, 32'd5, 1'b1);
    checkOutput("busy_calc", 32'(busy), 32'd1);
    checkOutput("ready_calc", 32'(ready), 32'd0);
    applyStimulus(2'b11, 32'd101010, 32'd3, 1'b1);
    applyStimulus(2'b11, 32'd1111, 32'd2, 1'b1);
    applyStimulus(2'b00, -32'sd23, 32'd4, 1'b1);
    applyStimulus(2'b10, -32'sd23, 32'd4, 1'b1);
    applyStimulus(2'b00, 32'd23, -32'sd4, 1'b1);
    applyStimulus(2'b10, 32'd23, -32'sd4, 1'b1);
    applyStimulus(2'b01, 32'd9999, 32'd0, 1'b1);
    applyStimulus(2'b10, 32'd9999, 32'd0, 1'b1);
    applyStimulus(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    applyStimulus(2'b01, 32'd3, 32'd34, 1'b1);
    applyStimulus(2'b11, 32'd3, 32'd34, 1'b1);
    applyStimulus(2'b01, 32'd1000, 32'd7, 1'b1);
    applyStimulus(2'b01, 32'd9999, 32'd1, 1'b1);
    drain();

    // Flush mid-calculation: no pulse, result register untouched.
    applyStimulus(2'b01, 32'd34, 32'd3, 1'b0);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_ready", 32'(ready), 32'd1);
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_result", result, last_res);
    repeat (40) @(negedge clk);
    applyStimulus(2'b01, 32'd34, 32'd3, 1'b1);
    drain();

    // start held high through most of CALC must not launch a second operation.
    applyStimulus(2'b01, 32'd1000, 32'd7, 1'b1);
    start = 1'b1;
    repeat (20) begin
      op       = 2'($urandom);
      dividend = $urandom;
      divisor  = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    drain();
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-CALC.
    applyStimulus(2'b01, 32'hDEAD_BEEF, 32'd77, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_ready", 32'(ready), 32'd1);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_valid", 32'(valid), 32'd0);
    checkOutput("async_result", result, 32'd0);
    sb.delete();
    last_res = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      applyStimulus(2'($urandom), pick(), pick(), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
